// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pkg
// Description : Shared constants and state encoding for the 4:1 round-robin
//               packet stream multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

  // Number of input lanes and width of a lane index
  localparam int NCH  = 4;
  localparam int SELW = 2;

  // IDLE: free to arbitrate; LOCKED: a multi-beat packet owns the output
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage : mux_pkg
`default_nettype wire

// File: rtl/rr_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_4
// Description : Combinational 4-way round-robin arbiter. The search starts
//               one position after ptr and wraps, so ptr itself has the
//               lowest priority.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_4
  import mux_pkg::*;
(
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            any
);

  // Walk ptr+1, ptr+2, ptr+3, ptr (mod 4) and grant the first requester
  always_comb begin
    logic [SELW-1:0] w_idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    w_idx   = '0;
    for (int i = 1; i <= NCH; i++) begin
      w_idx = ptr + SELW'(i);
      if (!any && req[w_idx]) begin
        any          = 1'b1;
        gnt_idx      = w_idx;
        gnt[w_idx]   = 1'b1;
      end
    end
  end

endmodule : rr_arbiter_4
`default_nettype wire

// File: rtl/mux_4x1_rr.sv
`default_nettype none
// ============================================================================
// Module      : mux_4x1_rr
// Description : Four-lane valid/ready packet multiplexer with round-robin
//               arbitration and a registered output stage. Each output beat
//               carries its source lane in out_sel; packets are never
//               interleaved.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_4x1_rr
  import mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_last,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready
);

  state_t            r_state;
  logic [SELW-1:0]   r_lock;
  logic [SELW-1:0]   r_ptr;
  logic [WIDTH-1:0]  r_out_data;
  logic [SELW-1:0]   r_out_sel;
  logic              r_out_last;
  logic              r_out_valid;

  logic [NCH-1:0]    w_gnt;
  logic [SELW-1:0]   w_gnt_idx;
  logic              w_any;
  logic              w_load;
  logic              w_accept;
  logic [SELW-1:0]   w_acc_idx;
  logic [WIDTH-1:0]  w_lane_data [NCH];

  // Unpack the flat input bus into per-lane words
  generate
    for (genvar g = 0; g < NCH; g++) begin : g_lane
      assign w_lane_data[g] = in_data[g*WIDTH +: WIDTH];
    end
  endgenerate

  rr_arbiter_4 u_arb (
    .req     (in_valid),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  // The output register can take a beat when it is empty or being drained
  assign w_load    = ~r_out_valid | out_ready;
  assign w_accept  = |(in_valid & in_ready);
  assign w_acc_idx = (r_state == LOCKED) ? r_lock : w_gnt_idx;

  // Ready goes only to the arbitration winner, or to the lock owner mid-packet
  always_comb begin
    in_ready = '0;
    if (w_load) begin
      if (r_state == LOCKED) begin
        in_ready[r_lock] = 1'b1;
      end else begin
        in_ready = w_gnt;
      end
    end
  end

  // FSM, lock/pointer bookkeeping and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_lock      <= '0;
      r_ptr       <= SELW'(NCH - 1);
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      if (w_accept) begin
        r_out_data  <= w_lane_data[w_acc_idx];
        r_out_sel   <= w_acc_idx;
        r_out_last  <= in_last[w_acc_idx];
        r_out_valid <= 1'b1;
        if (r_state == IDLE) begin
          r_ptr <= w_gnt_idx;
          if (!in_last[w_gnt_idx]) begin
            r_lock  <= w_gnt_idx;
            r_state <= LOCKED;
          end
        end else if (in_last[r_lock]) begin
          r_state <= IDLE;
        end
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_last  = r_out_last;
  assign out_valid = r_out_valid;

  // w_any is implied by a non-zero grant; keep it referenced for clarity
  logic w_unused;
  assign w_unused = w_any;

endmodule : mux_4x1_rr
`default_nettype wire

// File: tb/tb_mux_4x1_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_4x1_rr
// Description : Self-checking bench for mux_4x1_rr: directed scenarios plus
//               a randomized phase, all compared against a lane-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_4x1_rr;

  localparam int W = 8;

  logic          clk;
  logic          rst;
  logic [4*W-1:0] in_data;
  logic [3:0]    in_last;
  logic [3:0]    in_valid;
  logic [3:0]    in_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    out_sel;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;

  int errors;
  int checks;

  // Reference model: output holding register plus "who owns the output"
  int       m_ptr;       // lane served most recently by arbitration
  int       m_owner;     // lane mid-packet, or -1 when free
  bit       m_valid;
  int       m_data;
  int       m_sel;
  bit       m_last;

  mux_4x1_rr #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 3;
    m_owner = -1;
    m_valid = 0;
    m_data  = 0;
    m_sel   = 0;
    m_last  = 0;
  endtask

  // Which lane the model would serve this cycle (-1 for none)
  function automatic int model_pick();
    if (m_valid && !out_ready) return -1;
    if (m_owner >= 0) return m_owner;
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (m_ptr + k) % 4;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic int model_ready();
    if (m_valid && !out_ready) return 0;
    if (m_owner >= 0) return 1 << m_owner;
    if (model_pick() < 0) return 0;
    return 1 << model_pick();
  endfunction

  task automatic model_clock();
    int ch;
    if (m_valid && !out_ready) return;
    ch = model_pick();
    if (ch >= 0 && in_valid[ch]) begin
      m_valid = 1;
      m_data  = int'(in_data[ch*W +: W]);
      m_sel   = ch;
      m_last  = in_last[ch];
      m_ptr   = ch;
      m_owner = in_last[ch] ? -1 : ch;
    end else begin
      m_valid = 0;
    end
  endtask

  // One clock: inputs already driven after a falling edge
  task automatic step();
    #1;
    chk("in_ready", int'(in_ready), model_ready());
    @(posedge clk);
    model_clock();
    #1;
    chk("out_valid", int'(out_valid), int'(m_valid));
    if (m_valid) begin
      chk("out_data", int'(out_data), m_data);
      chk("out_sel",  int'(out_sel),  m_sel);
      chk("out_last", int'(out_last), int'(m_last));
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    model_reset();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data",  int'(out_data),  0);
    chk("rst_out_sel",   int'(out_sel),   0);
    chk("rst_out_last",  int'(out_last),  0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_lane(input int n, input logic [W-1:0] d, input logic l);
    in_data[n*W +: W] = d;
    in_last[n]        = l;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    in_data   = '0;
    in_last   = '0;
    in_valid  = '0;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Idle after reset: nothing valid, nothing ready
    #1 chk("idle_ready", int'(in_ready), 0);
    @(negedge clk);

    // Single-beat packet on lane 0
    set_lane(0, 8'hA5, 1'b1);
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    #1 chk("t1_ready", int'(in_ready), 4'b0001);
    step();
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_data",  int'(out_data), 8'hA5);
    chk("t1_sel",   int'(out_sel), 0);
    chk("t1_last",  int'(out_last), 1);

    // Fairness: four lanes continuously valid with single beats
    do_reset();
    for (int n = 0; n < 4; n++) set_lane(n, W'(8'h40 + n), 1'b1);
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t2_sel", int'(out_sel), i % 4);
      chk("t2_valid", int'(out_valid), 1);
    end

    // Three-beat packet on lane 2 while others keep requesting
    in_valid = 4'b0100;
    set_lane(2, 8'h11, 1'b0);
    step();
    chk("t3_sel_b1", int'(out_sel), 2);
    in_valid = 4'b1111;
    set_lane(2, 8'h22, 1'b0);
    #1 chk("t3_ready_b2", int'(in_ready), 4'b0100);
    step();
    chk("t3_sel_b2", int'(out_sel), 2);
    set_lane(2, 8'h33, 1'b1);
    #1 chk("t3_ready_b3", int'(in_ready), 4'b0100);
    step();
    chk("t3_sel_b3", int'(out_sel), 2);
    chk("t3_data_b3", int'(out_data), 8'h33);
    in_valid = 4'b1011;
    step();
    chk("t3_next_sel", int'(out_sel), 3);

    // Stall: downstream not ready for four cycles
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t4_stall_ready", int'(in_ready), 0);
      step();
      chk("t4_stall_sel", int'(out_sel), 3);
      chk("t4_stall_valid", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    #1 chk("t4_release_ready", int'(in_ready), 4'b0001);
    step();
    chk("t4_release_sel", int'(out_sel), 0);

    // Reset in the middle of a lane-1 packet
    do_reset();
    in_valid = 4'b0010;
    set_lane(1, 8'hB1, 1'b0);
    step();
    chk("t5_locked_sel", int'(out_sel), 1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("t5_async_clear", int'(out_valid), 0);
    #1 rst = 1'b0;
    in_valid = 4'b0011;
    set_lane(0, 8'hC0, 1'b1);
    set_lane(1, 8'hB2, 1'b0);
    step();
    chk("t5_after_rst_sel", int'(out_sel), 0);

    // Randomized traffic with random backpressure and withdrawals
    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < 4; n++) set_lane(n, W'($urandom), ($urandom_range(0, 2) == 0));
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mux_4x1_rr
`default_nettype wire
